address_range_decoder_multi: RTL

Programmable multi-range address decoder. It is the parametrised successor to the single-range arithmetic decoder.
- Holds RANGE_COUNT runtime-writable base/bound/enable entries.
- Compares each incoming address against all entries in a 2-stage pipeline.
- Returns a one-hot-per-range hit vector, a priority-encoded winning index and a miss flag.
- Sits between address generation and memory/IO port selection. Lets software remap ranges without resynthesis.

---
 rtl/address_range_decoder_multi_pkg.sv | 27 ++
 rtl/address_range_compare.sv | 15 +
 rtl/address_range_decoder_multi.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/address_range_decoder_multi_pkg.sv
// Shared types and helpers for the programmable multi-range address decoder.
package address_range_decoder_multi_pkg;

  // Address width the range-entry struct is built for; the top checks its ADDR_WIDTH against it.
  localparam int unsigned ARD_ADDR_WIDTH = 12;

  // Writes addressed to an entry index >= RANGE_COUNT are silently dropped.
  localparam bit ARD_DROP_OOR_CFG_WRITE = 1'b1;

  // One programmable range: inclusive [base, bound], active only when enable is set.
  typedef struct packed {
    logic [ARD_ADDR_WIDTH-1:0] base;
    logic [ARD_ADDR_WIDTH-1:0] bound;
    logic                      enable;
  } range_entry_t;

  // Ceiling log2, used to sanity-check INDEX_WIDTH against RANGE_COUNT.
  function automatic int unsigned ard_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = (n > 0) ? n - 1 : 0; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/address_range_compare.sv
// Single-range membership test: enable && base <= addr <= bound, unsigned, no wrap.
module address_range_compare #(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [ADDR_WIDTH-1:0] bound_i,
  input  logic                  enable_i,
  output logic                  hit_c
);

  // An inverted range (base > bound) can never satisfy both compares.
  assign hit_c = enable_i && (base_i <= addr_i) && (addr_i <= bound_i);

endmodule

// File: rtl/address_range_decoder_multi.sv
// Programmable multi-range address decoder, 2-stage pipeline (compare, then encode).
// Optional miss counter enabled by defining ADDR_RANGE_DECODER_MISS_COUNT_EN.
module address_range_decoder_multi
  import address_range_decoder_multi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = 12,
  parameter int unsigned RANGE_COUNT      = 4,
  parameter int unsigned INDEX_WIDTH      = 2,
  parameter int unsigned MISS_COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic                   cfg_wren,
  input  logic [INDEX_WIDTH-1:0] cfg_index,
  input  logic [ADDR_WIDTH-1:0]  cfg_base,
  input  logic [ADDR_WIDTH-1:0]  cfg_bound,
  input  logic                   cfg_enable,
  input  logic                   in_valid,
  input  logic [ADDR_WIDTH-1:0]  in_addr,
  output logic                   out_valid,
  output logic [RANGE_COUNT-1:0] out_hit_vector,
  output logic [INDEX_WIDTH-1:0] out_hit_index,
  output logic                   out_miss
`ifdef ADDR_RANGE_DECODER_MISS_COUNT_EN
  ,
  output logic [MISS_COUNT_WIDTH-1:0] miss_count
`endif
);

  // Elaboration-time parameter sanity checks.
  if (ADDR_WIDTH != ARD_ADDR_WIDTH) begin : g_bad_addr_width
    $error("ADDR_WIDTH must match the range entry struct width");
  end
  if (RANGE_COUNT < 2) begin : g_bad_range_count
    $error("RANGE_COUNT must be at least 2");
  end
  if (INDEX_WIDTH != ard_clog2(RANGE_COUNT)) begin : g_bad_index_width
    $error("INDEX_WIDTH must equal clog2(RANGE_COUNT)");
  end
  if (MISS_COUNT_WIDTH < 1) begin : g_bad_miss_width
    $error("MISS_COUNT_WIDTH must be at least 1");
  end
  if (!ARD_DROP_OOR_CFG_WRITE) begin : g_bad_policy
    $error("only the drop policy for out-of-range config writes is implemented");
  end

  range_entry_t [RANGE_COUNT-1:0] entry_q, entry_d;
  logic [RANGE_COUNT-1:0]         hit_c;

  logic                   s1_valid_q, s1_valid_d;
  logic [RANGE_COUNT-1:0] s1_hit_q, s1_hit_d;

  logic                   out_valid_q, out_valid_d;
  logic [RANGE_COUNT-1:0] out_hv_q, out_hv_d;
  logic [INDEX_WIDTH-1:0] out_idx_q, out_idx_d;
  logic                   out_miss_q, out_miss_d;

  // Config write: only the entry whose index matches is replaced; out-of-range indices match none.
  always_comb begin
    entry_d = entry_q;
    if (cfg_wren) begin
      for (int unsigned i = 0; i < RANGE_COUNT; i++) begin
        if (cfg_index == INDEX_WIDTH'(i)) begin
          entry_d[i].base   = cfg_base;
          entry_d[i].bound  = cfg_bound;
          entry_d[i].enable = cfg_enable;
        end
      end
    end
  end

  // One comparator per range, all looking at the entries as they stood before this edge.
  for (genvar g = 0; g < RANGE_COUNT; g++) begin : g_cmp
    address_range_compare #(
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_cmp (
      .addr_i  (in_addr),
      .base_i  (entry_q[g].base),
      .bound_i (entry_q[g].bound),
      .enable_i(entry_q[g].enable),
      .hit_c   (hit_c[g])
    );
  end

  // Stage-1 capture and stage-2 encode: lowest set bit wins, zeroed outputs when not valid.
  always_comb begin
    s1_valid_d  = in_valid;
    s1_hit_d    = hit_c;
    out_valid_d = s1_valid_q;
    out_hv_d    = s1_valid_q ? s1_hit_q : '0;
    out_idx_d   = '0;
    out_miss_d  = s1_valid_q && (s1_hit_q == '0);
    for (int unsigned k = 0; k < RANGE_COUNT; k++) begin
      if (out_hv_d[RANGE_COUNT-1-k]) begin
        out_idx_d = INDEX_WIDTH'(RANGE_COUNT-1-k);
      end
    end
  end

  // Entry table and pipeline registers; clear wipes everything and ignores inputs.
  always_ff @(posedge clock) begin
    if (clear) begin
      entry_q     <= '0;
      s1_valid_q  <= 1'b0;
      s1_hit_q    <= '0;
      out_valid_q <= 1'b0;
      out_hv_q    <= '0;
      out_idx_q   <= '0;
      out_miss_q  <= 1'b0;
    end else begin
      entry_q     <= entry_d;
      s1_valid_q  <= s1_valid_d;
      s1_hit_q    <= s1_hit_d;
      out_valid_q <= out_valid_d;
      out_hv_q    <= out_hv_d;
      out_idx_q   <= out_idx_d;
      out_miss_q  <= out_miss_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_hit_vector = out_hv_q;
  assign out_hit_index  = out_idx_q;
  assign out_miss       = out_miss_q;

`ifdef ADDR_RANGE_DECODER_MISS_COUNT_EN
  logic [MISS_COUNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

  // Saturating count of valid misses, advanced on the same edge stage 2 registers the miss.
  always_comb begin
    miss_cnt_d = miss_cnt_q;
    if (out_valid_d && out_miss_d && (miss_cnt_q != '1)) begin
      miss_cnt_d = miss_cnt_q + MISS_COUNT_WIDTH'(1);
    end
  end

  // Miss counter register.
  always_ff @(posedge clock) begin
    if (clear) begin
      miss_cnt_q <= '0;
    end else begin
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign miss_count = miss_cnt_q;
`endif

endmodule
